// File: rtl/page_dma.sv
// page_dma: register-programmed paged block-copy engine.
// Takes the memory bus with bus_req/bus_ack and copies 1-256 bytes from
// (SPAGE, SRC) to (DPAGE, DST). Optional fill mode is built in when the
// macro PAGE_DMA_FILL_EN is defined; the default build has no fill logic.
module page_dma (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  AD,
    input  logic [7:0]  DI,
    output logic [7:0]  DO,
    input  logic        rw,
    input  logic        cs,
    output logic        bus_req,
    input  logic        bus_ack,
    output logic [4:0]  m_page,
    output logic [15:0] m_addr,
    output logic [7:0]  m_dout,
    input  logic [7:0]  m_din,
    output logic        m_en,
    output logic        m_we,
    output logic        irq
);

    typedef enum logic [2:0] {IDLE, REQ, RD, LAT, WR, NXT, FIN} state_t;

    state_t      state, state_nxt;

    // Programming registers
    logic [7:0]  src_h, src_l, dst_h, dst_l, len;
    logic [4:0]  spage, dpage;
    logic        ien, done, fill;

    // Working copy of the transfer
    logic [15:0] src_cnt, dst_cnt;
    logic [8:0]  cnt;
    logic [7:0]  buf_q;
    logic        rd_prev;

    // Last values presented on the memory port, held between strobes
    logic [4:0]  page_q;
    logic [15:0] addr_q;
    logic [7:0]  dout_q;

    logic [2:0]  sel;
    logic        wr_en, busy, start_wr;
    logic [7:0]  rd_data;
    logic        unused_ad;

    assign unused_ad = ^AD[4:3];
    assign sel       = AD[2:0];
    assign wr_en     = cs & ~rw;
    assign busy      = (state != IDLE);
    assign start_wr  = wr_en && (sel == 3'd7) && DI[0] && !busy;
    assign irq       = done & ien;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and bus/strobe outputs; every bus state freezes while bus_ack is low
    always_comb begin
        state_nxt = state;
        bus_req   = 1'b0;
        m_en      = 1'b0;
        m_we      = 1'b0;
        case (state)
            IDLE: if (start_wr) state_nxt = REQ;
            REQ: begin
                bus_req = 1'b1;
                if (bus_ack) state_nxt = fill ? WR : RD;
            end
            RD: begin
                bus_req = 1'b1;
                if (bus_ack) begin
                    m_en      = 1'b1;
                    state_nxt = LAT;
                end
            end
            LAT: begin
                bus_req = 1'b1;
                if (bus_ack) state_nxt = WR;
            end
            WR: begin
                bus_req = 1'b1;
                if (bus_ack) begin
                    m_en      = 1'b1;
                    m_we      = 1'b1;
                    state_nxt = NXT;
                end
            end
            NXT: begin
                bus_req = 1'b1;
                if (bus_ack) state_nxt = (cnt == 9'd1) ? FIN : (fill ? WR : RD);
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port: drive the active address/data during a strobe, hold otherwise
    always_comb begin
        m_page = page_q;
        m_addr = addr_q;
        m_dout = dout_q;
        if (state == RD && bus_ack) begin
            m_page = spage;
            m_addr = src_cnt;
        end else if (state == WR && bus_ack) begin
            m_page = dpage;
            m_addr = dst_cnt;
`ifdef PAGE_DMA_FILL_EN
            m_dout = fill ? src_l : buf_q;
`else
            m_dout = buf_q;
`endif
        end
    end

    // Register read multiplexer
    always_comb begin
        rd_data = 8'h00;
        case (sel)
            3'd0: rd_data = src_h;
            3'd1: rd_data = src_l;
            3'd2: rd_data = dst_h;
            3'd3: rd_data = dst_l;
            3'd4: rd_data = {3'b000, spage};
            3'd5: rd_data = {3'b000, dpage};
            3'd6: rd_data = len;
            3'd7: rd_data = {busy, done, 3'b000, fill, ien, 1'b0};
            default: rd_data = 8'h00;
        endcase
    end

    // Register file: writes to 0-6 only while idle; CTRL IEN/DONE_CLR always accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_h <= 8'h00;
            src_l <= 8'h00;
            dst_h <= 8'h00;
            dst_l <= 8'h00;
            spage <= 5'd0;
            dpage <= 5'd0;
            len   <= 8'h00;
            ien   <= 1'b0;
            done  <= 1'b0;
            DO    <= 8'h00;
        end else begin
            if (cs && rw) DO <= rd_data;
            if (wr_en) begin
                case (sel)
                    3'd0: if (!busy) src_h <= DI;
                    3'd1: if (!busy) src_l <= DI;
                    3'd2: if (!busy) dst_h <= DI;
                    3'd3: if (!busy) dst_l <= DI;
                    3'd4: if (!busy) spage <= DI[4:0];
                    3'd5: if (!busy) dpage <= DI[4:0];
                    3'd6: if (!busy) len   <= DI;
                    3'd7: ien <= DI[1];
                    default: ;
                endcase
            end
            // Completion has priority over a simultaneous DONE_CLR
            if (state == FIN)
                done <= 1'b1;
            else if (start_wr || (wr_en && sel == 3'd7 && DI[6]))
                done <= 1'b0;
        end
    end

`ifdef PAGE_DMA_FILL_EN
    // FILL control bit, only writable while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fill <= 1'b0;
        else if (wr_en && sel == 3'd7 && !busy)
            fill <= DI[2];
    end
`else
    assign fill = 1'b0;
`endif

    // Working counters, byte buffer and held memory-port values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_cnt <= 16'h0000;
            dst_cnt <= 16'h0000;
            cnt     <= 9'd0;
            buf_q   <= 8'h00;
            rd_prev <= 1'b0;
            page_q  <= 5'd0;
            addr_q  <= 16'h0000;
            dout_q  <= 8'h00;
        end else begin
            if (start_wr) begin
                src_cnt <= {src_h, src_l};
                dst_cnt <= {dst_h, dst_l};
                cnt     <= (len == 8'h00) ? 9'd256 : {1'b0, len};
            end else if (state == NXT && bus_ack) begin
                if (!fill) src_cnt <= src_cnt + 16'd1;
                dst_cnt <= dst_cnt + 16'd1;
                cnt     <= cnt - 9'd1;
            end
            // Read data is valid exactly one cycle after the read strobe,
            // so capture on the first LAT cycle even if the bus was just dropped
            rd_prev <= (state == RD) && bus_ack;
            if (state == LAT && rd_prev) buf_q <= m_din;
            page_q <= m_page;
            addr_q <= m_addr;
            dout_q <= m_dout;
        end
    end

endmodule

// File: tb/tb_page_dma.sv
// tb_page_dma: randomized scoreboard bench for page_dma with a paged memory
// model and a bus arbiter that can withhold the grant.
module tb_page_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  AD;
    logic [7:0]  DI;
    logic [7:0]  DO;
    logic        rw;
    logic        cs;
    logic        bus_req;
    logic        bus_ack;
    logic [4:0]  m_page;
    logic [15:0] m_addr;
    logic [7:0]  m_dout;
    logic [7:0]  m_din;
    logic        m_en;
    logic        m_we;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [logic [20:0]];
    logic [28:0] exp_wr [$];
    logic [20:0] exp_rd [$];

    int   req_cyc = 0;
    int   ack_cyc = 0;
    int   wr_seen = 0;
    int   req_base, ack_base;
    int   stall_mode;
    int   req_k = 0;
    logic blk = 1'b0;

    assign bus_ack = bus_req & ~blk;

    page_dma dut (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
        .bus_req(bus_req), .bus_ack(bus_ack), .m_page(m_page), .m_addr(m_addr),
        .m_dout(m_dout), .m_din(m_din), .m_en(m_en), .m_we(m_we), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Untouched memory holds a position-dependent pattern
    function automatic logic [7:0] mem_rd(input logic [20:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]};
    endfunction

    // Paged memory: read data appears one cycle after the read strobe
    always @(posedge clk) begin
        if (m_en && m_we) mem[{m_page, m_addr}] = m_dout;
        if (m_en && !m_we) m_din <= mem_rd({m_page, m_addr});
    end

    // Bus arbiter: decides the grant for each requested cycle
    always @(posedge clk) begin
        #1;
        if (bus_req) begin
            case (stall_mode)
                1:       blk = (req_k < 10) || (req_k >= 17 && req_k <= 19);
                2:       blk = ($urandom_range(0, 3) == 0);
                default: blk = 1'b0;
            endcase
            req_k++;
        end else begin
            blk   = 1'b0;
            req_k = 0;
        end
    end

    // Monitor: checks every memory strobe against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_req) req_cyc++;
            if (bus_req && bus_ack) ack_cyc++;
            if (m_en) chk("m_en_needs_ack", {31'd0, bus_ack}, 32'd1);
            if (m_en && m_we) begin
                wr_seen++;
                if (exp_wr.size() == 0)
                    chk("write_unexpected", {3'b000, m_page, m_addr, m_dout}, 32'hFFFFFFFF);
                else
                    chk("write", {3'b000, m_page, m_addr, m_dout}, {3'b000, exp_wr.pop_front()});
            end
            if (m_en && !m_we) begin
                if (exp_rd.size() == 0)
                    chk("read_unexpected", {11'd0, m_page, m_addr}, 32'hFFFFFFFF);
                else
                    chk("read", {11'd0, m_page, m_addr}, {11'd0, exp_rd.pop_front()});
            end
        end
    end

    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        AD = {2'b00, a};
        DI = d;
        rw = 1'b0;
        cs = 1'b1;
        @(posedge clk);
        #1;
        cs = 1'b0;
        rw = 1'b1;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        AD = {2'b00, a};
        rw = 1'b1;
        cs = 1'b1;
        @(posedge clk);
        #1;
        d  = DO;
        cs = 1'b0;
    endtask

    // Program a transfer, queue the byte-level expectations, then start it
    task automatic xfer(input logic [4:0] sp, input logic [15:0] src, input logic [4:0] dp,
                        input logic [15:0] dst, input logic [7:0] len, input logic ien,
                        input logic fill);
        int n;
        logic [15:0] sa, da;
        reg_wr(3'd0, src[15:8]);
        reg_wr(3'd1, src[7:0]);
        reg_wr(3'd2, dst[15:8]);
        reg_wr(3'd3, dst[7:0]);
        reg_wr(3'd4, {3'b000, sp});
        reg_wr(3'd5, {3'b000, dp});
        reg_wr(3'd6, len);
        n = (len == 8'h00) ? 256 : int'(len);
        for (int i = 0; i < n; i++) begin
            sa = src + 16'(i);
            da = dst + 16'(i);
            if (!fill) exp_rd.push_back({sp, sa});
            exp_wr.push_back({dp, da, fill ? src[7:0] : mem_rd({sp, sa})});
        end
        req_base = req_cyc;
        ack_base = ack_cyc;
        reg_wr(3'd7, {5'b00000, fill, ien, 1'b1});
    endtask

    // Wait for BUSY to clear, then check status, leftovers and granted-cycle count
    task automatic finish_xfer(input int n, input int per_byte, input logic [7:0] exp_ctrl,
                               input logic exp_irq);
        logic [7:0] d;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reg_rd(3'd7, d);
            if (!d[7]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("busy_clears", {31'd0, ok}, 32'd1);
        chk("ctrl_after", {24'd0, d}, {24'd0, exp_ctrl});
        chk("irq_after", {31'd0, irq}, {31'd0, exp_irq});
        chk("wr_left", exp_wr.size(), 0);
        chk("rd_left", exp_rd.size(), 0);
        // one granted REQ cycle plus per_byte cycles per byte
        chk("granted_cycles", ack_cyc - ack_base, per_byte * n + 1);
    endtask

    initial begin
        logic [7:0] d;
        logic [4:0] sp, dp;
        logic [15:0] src, dst;
        logic [7:0] len;
        logic ien;
        int w0;
        bit ok;

        rst = 1'b1;
        cs = 1'b0;
        rw = 1'b1;
        AD = 5'd0;
        DI = 8'h00;
        stall_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_DO", {24'd0, DO}, 0);
        chk("rst_bus_req", {31'd0, bus_req}, 0);
        chk("rst_m_en", {31'd0, m_en}, 0);
        chk("rst_m_addr", {16'd0, m_addr}, 0);
        chk("rst_m_page", {27'd0, m_page}, 0);
        chk("rst_irq", {31'd0, irq}, 0);
        @(negedge clk);
        rst = 1'b0;
        reg_rd(3'd7, d);
        chk("rst_ctrl", {24'd0, d}, 0);

        // Basic 4-byte copy
        mem[{5'd3, 16'h8000}] = 8'h11;
        mem[{5'd3, 16'h8001}] = 8'h22;
        mem[{5'd3, 16'h8002}] = 8'h33;
        mem[{5'd3, 16'h8003}] = 8'h44;
        xfer(5'd3, 16'h8000, 5'd5, 16'h9000, 8'd4, 1'b1, 1'b0);
        reg_rd(3'd7, d);
        chk("ctrl_busy", {24'd0, d}, 32'h82);
        finish_xfer(4, 4, 8'h42, 1'b1);
        chk("mem_9000", {24'd0, mem_rd({5'd5, 16'h9000})}, 32'h11);
        chk("mem_9001", {24'd0, mem_rd({5'd5, 16'h9001})}, 32'h22);
        chk("mem_9002", {24'd0, mem_rd({5'd5, 16'h9002})}, 32'h33);
        chk("mem_9003", {24'd0, mem_rd({5'd5, 16'h9003})}, 32'h44);
        reg_wr(3'd7, 8'h42);
        reg_rd(3'd7, d);
        chk("ctrl_done_clr", {24'd0, d}, 32'h02);
        chk("irq_cleared", {31'd0, irq}, 0);

        // Address wrap at $FFFF on both sides
        xfer(5'd7, 16'hFFFE, 5'd9, 16'hFFFF, 8'd3, 1'b0, 1'b0);
        finish_xfer(3, 4, 8'h40, 1'b0);

        // Grant withheld 10 cycles, then dropped 3 cycles during WR of byte 2
        stall_mode = 1;
        xfer(5'd2, 16'h1234, 5'd4, 16'h5678, 8'd5, 1'b1, 1'b0);
        finish_xfer(5, 4, 8'h42, 1'b1);
        chk("stall_total_cycles", req_cyc - req_base, 4 * 5 + 1 + 13);
        stall_mode = 0;

        // LEN=0 copies 256 bytes; START and SRCL writes while busy are ignored
        xfer(5'd1, 16'h20C0, 5'd6, 16'h3000, 8'd0, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        reg_wr(3'd7, 8'h03);
        reg_wr(3'd1, 8'h77);
        finish_xfer(256, 4, 8'h42, 1'b1);
        reg_rd(3'd1, d);
        chk("srcl_unchanged", {24'd0, d}, 32'hC0);

        // Asynchronous reset in the middle of a 256-byte transfer
        xfer(5'd1, 16'h2000, 5'd8, 16'h0100, 8'd0, 1'b1, 1'b0);
        w0 = wr_seen;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (wr_seen - w0 >= 100) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_byte_100", {31'd0, ok}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_bus_req", {31'd0, bus_req}, 0);
        chk("rst_mid_m_en", {31'd0, m_en}, 0);
        exp_wr.delete();
        exp_rd.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reg_rd(3'd7, d);
        chk("rst_mid_ctrl", {24'd0, d}, 0);
        reg_rd(3'd4, d);
        chk("rst_mid_spage", {24'd0, d}, 0);
        chk("rst_mid_irq", {31'd0, irq}, 0);

        // Randomized transfers with random grant stalls
        stall_mode = 2;
        for (int t = 0; t < 6; t++) begin
            sp  = 5'($urandom_range(0, 31));
            dp  = 5'((int'(sp) + 1 + int'($urandom_range(0, 30))) % 32);
            src = (t % 2 == 0) ? 16'($urandom) : (16'hFFF0 + 16'($urandom_range(0, 15)));
            dst = (t % 3 == 0) ? (16'hFFE8 + 16'($urandom_range(0, 23))) : 16'($urandom);
            len = 8'($urandom_range(1, 40));
            ien = 1'($urandom_range(0, 1));
            xfer(sp, src, dp, dst, len, ien, 1'b0);
            finish_xfer(int'(len), 4, {1'b0, 1'b1, 3'b000, 1'b0, ien, 1'b0}, ien);
        end
        stall_mode = 0;

`ifdef PAGE_DMA_FILL_EN
        // Fill mode: SRCL value written to every destination byte, no reads
        xfer(5'd0, 16'h00A5, 5'd10, 16'h4000, 8'd8, 1'b0, 1'b1);
        finish_xfer(8, 2, 8'h44, 1'b0);
        for (int i = 0; i < 8; i++)
            chk("fill_mem", {24'd0, mem_rd({5'd10, 16'h4000 + 16'(i)})}, 32'hA5);
`else
        // Without the fill option, CTRL bit2 does not stick
        reg_wr(3'd7, 8'h04);
        reg_rd(3'd7, d);
        chk("fill_absent", {24'd0, d}, 32'h40);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/page_dma.md
Name: page_dma

Overview:
- Register-programmed block-copy engine for the paged memory system.
- Moves 1–256 bytes from (source page, source address) to (destination page, destination address) without CPU involvement.
- Takes the memory bus from the CPU with a bus_req/bus_ack handshake. Drives page number and address directly to the paged memory decoder.
- Sits on the peripheral register bus next to the page select register block.

Parameters:
- none (register offsets and widths are fixed)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- AD  in  5  register address; AD[2:0] selects the register, AD[4:3] ignored (decoded externally into cs)
- DI  in  8  register write data
- DO  out  8  register read data (registered)
- rw  in  1  1 = read, 0 = write
- cs  in  1  block select
- bus_req  out  1  request for the memory bus
- bus_ack  in  1  bus granted; CPU is halted while high
- m_page  out  5  page number presented to the memory decoder
- m_addr  out  16  memory address
- m_dout  out  8  write data to memory
- m_din  in  8  read data from memory; valid one cycle after a read strobe
- m_en  out  1  memory access strobe
- m_we  out  1  1 = write, valid with m_en
- irq  out  1  completion interrupt, level

Behaviour:
- Registers (AD[2:0]):
  - 0 SRCH
  - 1 SRCL
  - 2 DSTH
  - 3 DSTL
  - 4 SPAGE (bits 4:0; reads 000 in bits 7:5)
  - 5 DPAGE (bits 4:0)
  - 6 LEN (0 means 256)
  - 7 CTRL/STATUS
- CTRL write bits:
  - bit0 START: self-clearing
  - bit1 IEN
  - bit6 DONE_CLR: 1 clears DONE
- CTRL read value: {BUSY, DONE, 3'b000, FILL, IEN, 1'b0}. FILL reads 0 unless the optional feature is compiled in.
- Register access:
  - Accesses are sampled on posedge clk when cs=1.
  - Reads load DO on that edge.
  - Writes update the register on that edge.
- Writes while BUSY:
  - Writes to registers 0–6 are ignored.
  - CTRL writes may change IEN and DONE_CLR; START is ignored.
- Reset values:
  - All registers 0, DO=0.
  - bus_req=0, m_en=0, m_we=0, m_page=0, m_addr=0, m_dout=0, irq=0.
  - FSM goes to IDLE.
- FSM states: IDLE, REQ, RD, LAT, WR, NXT, FIN.
  - IDLE: START written with 1 → copy SRC, DST, LEN into working counters, set BUSY, clear DONE → REQ.
  - REQ: bus_req=1. Wait for bus_ack=1 → RD.
  - RD: m_en=1, m_we=0, m_page=SPAGE, m_addr=src → LAT.
  - LAT: capture m_din into the byte buffer → WR.
  - WR: m_en=1, m_we=1, m_page=DPAGE, m_addr=dst, m_dout=buffer → NXT.
  - NXT: src+1, dst+1 (16-bit wrap $FFFF→$0000, page unchanged), count−1. If count reaches 0 → FIN, else → RD.
  - FIN: bus_req=0, BUSY=0, DONE=1 → IDLE.
- Timing: 4 cycles per byte after the grant. LEN=N gives 4N cycles from RD entry to FIN.
- bus_req stays high from REQ through NXT of the last byte (one bus tenure per transfer).
- bus_ack dropping in RD/LAT/WR/NXT:
  - FSM holds its state with m_en=0.
  - Resumes in the same state when bus_ack returns.
  - LAT still captures on the first cycle after RD regardless.
- m_en is high only in RD and WR while bus_ack=1. m_page, m_addr and m_dout hold their last values otherwise.
- irq = DONE & IEN (combinational from registered bits).
- DONE_CLR and FIN in the same cycle: DONE ends at 1 (set wins).
- Asynchronous reset mid-transfer: bus_req drops immediately and all state clears. A partially written destination is left as is.

Optional Feature:
- Macro PAGE_DMA_FILL_EN.
- When defined:
  - CTRL bit2 is FILL, read/write.
  - With FILL=1 the transfer skips RD/LAT: sequence is WR→NXT per byte, with m_dout = SRCL register value.
  - Only dst and count advance; 2 cycles per byte.
- When undefined:
  - CTRL bit2 is write-ignored and reads 0.
  - No fill datapath is synthesized.

Test Plan:
- Copy 4 bytes: SPAGE=3, SRC=$8000 with memory $11,$22,$33,$44; DPAGE=5, DST=$9000; LEN=4; START with IEN=1, bus_ack tied to bus_req.
  → page 5 $9000–$9003 = $11..$44; BUSY read 1 during the transfer; 16 cycles RD→FIN; DONE=1; irq=1.
- Write DONE_CLR=1 after the copy → CTRL reads $02 (IEN only); irq=0.
- Wrap: SRC=$FFFE, DST=$FFFF, LEN=3 → reads $FFFE,$FFFF,$0000; writes $FFFF,$0000,$0001; m_page constant throughout.
- Grant stall: hold bus_ack=0 for 10 cycles after the request, then drop it for 3 cycles during WR of byte 2.
  → no m_en while bus_ack=0; correct data written; total cycles extended by exactly the stall cycles.
- LEN=0 copies 256 bytes. A START or write to SRCL during the transfer has no effect. Async rst at byte 100 → bus_req=0 immediately; CTRL reads $00.
- With PAGE_DMA_FILL_EN: FILL=1, SRCL=$A5, DST=$4000, LEN=8 → $4000–$4007 = $A5; no m_we=0 strobes; 16 cycles.
